nt_node_lane_monitor: RTL and testbench

Parametrised, multi-lane Nt-node subcircuit with a built-in rare-value run monitor for trojan-detection benchmarking. Each lane evaluates the registered three-flop Nt-node function and produces the node output. A per-lane saturating run counter tracks consecutive cycles in which the node sits at its rare value. A sticky trigger flags any lane whose run reaches a threshold, and the lowest-index lane to trigger first is captured. The block sits beside the netlist subcircuits as the observation point for rare-node activation.

---
 rtl/nt_node_lane_monitor_if.sv | 37 +++
 rtl/nt_node_lane_monitor.sv | 100 ++++++++++
 tb/tb_nt_node_lane_monitor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nt_node_lane_monitor_if.sv
// Bus bundle for nt_node_lane_monitor.
// master drives lane inputs and monitor controls; slave is the monitor.
interface nt_node_lane_monitor_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
);
  localparam int FL_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                   en;
  logic                   clr;
  logic [LANES-1:0]       I3966;
  logic [LANES-1:0]       I6459;
  logic [LANES-1:0]       I6657;
  logic [LANES-1:0]       I6705;
  logic [LANES-1:0]       I6318;
  logic [LANES-1:0]       I7652;
  logic [LANES-1:0]       I8124;
  logic [LANES*CNT_W-1:0] run_cnt;
  logic [LANES-1:0]       trig;
  logic                   trig_any;
  logic [FL_W-1:0]        first_lane;
  logic                   first_valid;

  modport master (
    output en, clr, I3966, I6459, I6657,
    output I6705, I6318, I7652,
    input  I8124, run_cnt, trig, trig_any,
    input  first_lane, first_valid
  );

  modport slave (
    input  en, clr, I3966, I6459, I6657,
    input  I6705, I6318, I7652,
    output I8124, run_cnt, trig, trig_any,
    output first_lane, first_valid
  );
endinterface

// File: rtl/nt_node_lane_monitor.sv
// Multi-lane Nt-node with rare-value run counters,
// sticky per-lane triggers and first-trigger lane capture.
module nt_node_lane_monitor #(
  parameter int               LANES    = 4,
  parameter int               CNT_W    = 8,
  parameter int               THRESH   = 16,
  parameter logic [LANES-1:0] RARE_VAL = '0
) (
  input  logic                  I1470_clk,
  input  logic                  I1477_rst,
  nt_node_lane_monitor_if.slave bus
);
  localparam int FL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TH1 = CNT_W'(THRESH - 1);

  logic [LANES-1:0] ra_q, ra_d;
  logic [LANES-1:0] rb_q, rb_d;
  logic [LANES-1:0] rc_q, rc_d;
  logic [LANES-1:0] node;

  logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0]            trig_q, trig_d;
  logic [LANES-1:0]            hit;
  logic [FL_W-1:0]             fl_q, fl_d;
  logic                        fv_q, fv_d;

  // Nt-node register inputs and the node output
  always_comb begin
    ra_d = bus.I3966;
    rb_d = ~(bus.I6705 & bus.I6657);
    rc_d = ~(ra_q & bus.I6459);
    node = ~rc_q | (rb_q & bus.I7652 & bus.I6318);
  end

  // Run counting, trigger set and first-lane capture
  always_comb begin
    cnt_d  = cnt_q;
    trig_d = trig_q;
    fl_d   = fl_q;
    fv_d   = fv_q;
    hit    = '0;
    if (bus.clr) begin
      cnt_d  = '0;
      trig_d = '0;
      fl_d   = '0;
      fv_d   = 1'b0;
    end else if (bus.en) begin
      for (int l = 0; l < LANES; l++) begin
        if (node[l] == RARE_VAL[l]) begin
          if (cnt_q[l] != CNT_MAX) begin
            cnt_d[l] = cnt_q[l] + CNT_W'(1);
          end
          if (cnt_q[l] == CNT_TH1) begin
            hit[l] = 1'b1;
          end
        end else begin
          cnt_d[l] = '0;
        end
      end
      trig_d = trig_q | hit;
      if (!fv_q && (|hit)) begin
        fv_d = 1'b1;
        for (int l = LANES - 1; l >= 0; l--) begin
          if (hit[l]) begin
            fl_d = FL_W'(l);
          end
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      cnt_q  <= '0;
      trig_q <= '0;
      fl_q   <= '0;
      fv_q   <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      rc_q   <= rc_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
      fl_q   <= fl_d;
      fv_q   <= fv_d;
    end
  end

  assign bus.I8124       = node;
  assign bus.run_cnt     = cnt_q;
  assign bus.trig        = trig_q;
  assign bus.trig_any    = |trig_q;
  assign bus.first_lane  = fl_q;
  assign bus.first_valid = fv_q;
endmodule

// File: tb/tb_nt_node_lane_monitor.sv
// Bench for nt_node_lane_monitor: directed table, corner sequences
// and random stimulus against a path-level reference model.
module tb_nt_node_lane_monitor;
  logic clk = 1'b0;
  logic rst, en, clr;
  logic [3:0] a, b, c, d, e, f;
  int checks = 0;
  int failures = 0;

  nt_node_lane_monitor_if #(.LANES(4), .CNT_W(8)) bus0 ();
  nt_node_lane_monitor_if #(.LANES(4), .CNT_W(4)) bus1 ();

  assign bus0.en = en;    assign bus1.en = en;
  assign bus0.clr = clr;  assign bus1.clr = clr;
  assign bus0.I3966 = a;  assign bus1.I3966 = a;
  assign bus0.I6459 = b;  assign bus1.I6459 = b;
  assign bus0.I6657 = c;  assign bus1.I6657 = c;
  assign bus0.I6705 = d;  assign bus1.I6705 = d;
  assign bus0.I6318 = e;  assign bus1.I6318 = e;
  assign bus0.I7652 = f;  assign bus1.I7652 = f;

  nt_node_lane_monitor #(
    .LANES(4), .CNT_W(8), .THRESH(16), .RARE_VAL(4'b0000)
  ) u0 (.I1470_clk(clk), .I1477_rst(rst), .bus(bus0));

  nt_node_lane_monitor #(
    .LANES(4), .CNT_W(4), .THRESH(15), .RARE_VAL(4'b0000)
  ) u1 (.I1470_clk(clk), .I1477_rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Node is derived from input history: the I3966 sample two edges
  // back with the I6459 sample one edge back, the I6705/I6657 sample
  // one edge back, and live I7652/I6318. A reset edge voids history.
  logic [3:0] h1b, h1c, h1d, h1a, h2a;
  bit h1v = 0, h2v = 0, model_ok = 0;
  int run [2][4];
  logic [3:0] mtrig [2];
  int mfl [2];
  bit mfv [2];
  int th [2] = '{16, 15};
  int mx [2] = '{255, 15};

  function automatic logic [3:0] m_node();
    logic [3:0] n;
    if (!h1v) return 4'hF;
    n = (h2v ? (h2a & h1b) : 4'h0) | (~(h1c & h1d) & f & e);
    return n;
  endfunction

  function automatic int sat(int r, int m);
    return (r > m) ? m : r;
  endfunction

  task automatic m_edge();
    logic [3:0] nd;
    logic [3:0] nw;
    nd = m_node();
    if (rst) begin
      h1v = 0; h2v = 0; model_ok = 1;
      for (int k = 0; k < 2; k++) begin
        for (int l = 0; l < 4; l++) run[k][l] = 0;
        mtrig[k] = 0; mfl[k] = 0; mfv[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int l = 0; l < 4; l++) run[k][l] = 0;
        mtrig[k] = 0; mfl[k] = 0; mfv[k] = 0;
      end else if (en) begin
        nw = 0;
        for (int l = 0; l < 4; l++) begin
          if (nd[l] == 1'b0) begin
            run[k][l]++;
            if (run[k][l] == th[k]) nw[l] = 1'b1;
          end else begin
            run[k][l] = 0;
          end
        end
        mtrig[k] |= nw;
        if (!mfv[k] && nw != 0) begin
          mfv[k] = 1;
          for (int l = 3; l >= 0; l--) if (nw[l]) mfl[k] = l;
        end
      end
    end
    h2a = h1a; h2v = h1v;
    h1a = a; h1b = b; h1c = c; h1d = d; h1v = 1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("node0", 32'(bus0.I8124), 32'(m_node()));
    chk("node1", 32'(bus1.I8124), 32'(m_node()));
    for (int l = 0; l < 4; l++) begin
      chk("cnt0", 32'(bus0.run_cnt[l*8 +: 8]), sat(run[0][l], mx[0]));
      chk("cnt1", 32'(bus1.run_cnt[l*4 +: 4]), sat(run[1][l], mx[1]));
    end
    chk("trig0", 32'(bus0.trig), 32'(mtrig[0]));
    chk("trig1", 32'(bus1.trig), 32'(mtrig[1]));
    chk("any0", 32'(bus0.trig_any), 32'(mtrig[0] != 0));
    chk("any1", 32'(bus1.trig_any), 32'(mtrig[1] != 0));
    chk("fv0", 32'(bus0.first_valid), 32'(mfv[0]));
    chk("fv1", 32'(bus1.first_valid), 32'(mfv[1]));
    if (mfv[0]) chk("fl0", 32'(bus0.first_lane), mfl[0]);
    if (mfv[1]) chk("fl1", 32'(bus1.first_lane), mfl[1]);
  endtask

  task automatic step();
    #2;
    if (model_ok) check_all();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(logic [3:0] ev, int n);
    e = ev;
    repeat (n) step();
    #1;
  endtask

  function automatic logic [3:0] rbits(int n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ($urandom_range(n - 1) == 0);
    return r;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit rst;
    logic [3:0] a, b, c, d, e, f, exp;
    bit chk;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(bit r, logic [3:0] va, logic [3:0] vb,
                              logic [3:0] vc, logic [3:0] vd,
                              logic [3:0] ve, logic [3:0] vf,
                              logic [3:0] x, bit k);
    vec_t v;
    v.rst = r; v.a = va; v.b = vb; v.c = vc; v.d = vd;
    v.e = ve; v.f = vf; v.exp = x; v.chk = k;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 0; clr = 0;
    a = 0; b = 0; c = 0; d = 0; e = 0; f = 0;

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 4'hF, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 4'hF, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 1);
    tbl[3]  = mk(0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 1);
    tbl[4]  = mk(0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 1);
    tbl[5]  = mk(0, 4'hF, 4'hF, 0, 0, 0, 0, 4'hF, 1);
    tbl[6]  = mk(0, 0, 0, 4'hF, 0, 4'hF, 4'hF, 4'hF, 1);
    tbl[7]  = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1);
    tbl[8]  = mk(0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    tbl[9]  = mk(0, 0, 0, 4'hF, 4'hF, 0, 4'hF, 4'h0, 1);
    tbl[10] = mk(0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
    tbl[11] = mk(0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1);
    tbl[12] = mk(0, 0, 0, 0, 4'hF, 4'hF, 0, 4'h0, 1);
    tbl[13] = mk(0, 0, 0, 0, 4'hF, 4'h5, 4'hF, 4'h5, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      a = tbl[i].a; b = tbl[i].b; c = tbl[i].c;
      d = tbl[i].d; e = tbl[i].e; f = tbl[i].f;
      #2;
      if (tbl[i].chk) chk("tbl_node", 32'(bus0.I8124), 32'(tbl[i].exp));
      step();
    end

    // post-reset state after the table (no counting happened)
    chk("rst_cnt", 32'(bus0.run_cnt), 0);
    chk("rst_fv", 32'(bus0.first_valid), 0);

    // node becomes e once a=c=d=0 settles; f=1
    a = 0; b = 0; c = 0; d = 0; f = 4'hF;
    en = 1; clr = 1;
    hold(4'hF, 2);
    clr = 0;

    // trigger at threshold on lane 2
    hold(4'b1011, 15);
    chk("thr_cnt15", 32'(bus0.run_cnt[23:16]), 15);
    chk("thr_trig15", 32'(bus0.trig), 0);
    hold(4'b1011, 1);
    chk("thr_cnt16", 32'(bus0.run_cnt[23:16]), 16);
    chk("thr_trig16", 32'(bus0.trig), 4'b0100);
    chk("thr_any", 32'(bus0.trig_any), 1);
    chk("thr_fl", 32'(bus0.first_lane), 2);
    chk("thr_fv", 32'(bus0.first_valid), 1);

    // run break on lane 1, with an en gap inside the run
    clr = 1; hold(4'hF, 1); clr = 0;
    hold(4'b1101, 10);
    hold(4'hF, 1);
    chk("brk_cnt0", 32'(bus0.run_cnt[15:8]), 0);
    hold(4'b1101, 3);
    en = 0; hold(4'hF, 2); en = 1;
    hold(4'b1101, 2);
    chk("brk_cnt5", 32'(bus0.run_cnt[15:8]), 5);
    chk("brk_trig", 32'(bus0.trig[1]), 0);

    // simultaneous triggers on lanes 1 and 3, then lane 0
    clr = 1; hold(4'hF, 1); clr = 0;
    hold(4'b0101, 16);
    chk("sim_trig", 32'(bus0.trig), 4'b1010);
    chk("sim_fl", 32'(bus0.first_lane), 1);
    hold(4'b0100, 16);
    chk("sim_trig2", 32'(bus0.trig), 4'b1011);
    chk("sim_fl2", 32'(bus0.first_lane), 1);

    // saturation on the 4-bit instance, then clear with en high
    clr = 1; hold(4'hF, 1); clr = 0;
    hold(4'b1110, 20);
    chk("sat_cnt", 32'(bus1.run_cnt[3:0]), 15);
    chk("sat_trig", 32'(bus1.trig), 4'b0001);
    hold(4'b1110, 3);
    chk("sat_hold", 32'(bus1.run_cnt[3:0]), 15);
    clr = 1; hold(4'b1110, 1); clr = 0;
    chk("clr_cnt0", 32'(bus0.run_cnt), 0);
    chk("clr_cnt1", 32'(bus1.run_cnt), 0);
    chk("clr_trig", 32'({bus0.trig, bus1.trig}), 0);
    chk("clr_any", 32'({bus0.trig_any, bus1.trig_any}), 0);
    chk("clr_fv", 32'({bus0.first_valid, bus1.first_valid}), 0);
    chk("clr_fl", 32'(bus0.first_lane), 0);
    chk("clr_node", 32'(bus0.I8124), 4'b1110);

    // reset mid-run
    hold(4'b1110, 5);
    rst = 1; hold(4'b1110, 1);
    chk("mrst_node", 32'(bus0.I8124), 4'hF);
    chk("mrst_cnt", 32'(bus0.run_cnt), 0);
    chk("mrst_trig", 32'(bus0.trig), 0);
    chk("mrst_fv", 32'(bus0.first_valid), 0);
    rst = 0;
    hold(4'b1110, 4);

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(59) == 0);
      clr = ($urandom_range(39) == 0);
      en = ($urandom_range(3) != 0);
      a = rbits(8);
      b = 4'($urandom);
      c = 4'($urandom);
      d = 4'($urandom);
      e = rbits(6);
      f = 4'($urandom);
      step();
    end
    rst = 0; clr = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
